// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier sequencing controller.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        ITER = ST_ITER,
        DONE = ST_DONE
    } mul_state_e;

    // Product register control opcodes
    localparam logic [1:0] MUL_OP_NONE      = 2'd0;
    localparam logic [1:0] MUL_OP_LOAD      = 2'd1;
    localparam logic [1:0] MUL_OP_ADD_SHIFT = 2'd2;
    localparam logic [1:0] MUL_OP_SHIFT     = 2'd3;

    function automatic logic [1:0] mul_op(input logic load, input logic add, input logic shift);
        if (load)
            return MUL_OP_LOAD;
        else if (shift)
            return add ? MUL_OP_ADD_SHIFT : MUL_OP_SHIFT;
        else
            return MUL_OP_NONE;
    endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// Clearable, saturating iteration counter with a terminal-count flag.
module mul_iter_counter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             term_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign term_c = (count_q == CNT_W'(WIDTH - 1));
    assign count  = count_q;

    // Holds at WIDTH-1 rather than wrapping; clear has priority.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && !term_c)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/mul_control.sv
// Sequencing FSM for the shift/add multiplier Product register.
// Optional zero-multiplier bypass enabled by defining MUL_CTRL_ZERO_SKIP_EN.
module mul_control
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lsb,
    input  logic             mplier_zero,
    output logic             load_ctrl,
    output logic             adding_ctrl,
    output logic             shift_ctrl,
    output logic [CNT_W-1:0] w_ctrl_Product,
    output logic             rdy,
    output logic             busy,
    output logic             done
);

    mul_state_e state_q, state_d;
    logic load_q, load_d;
    logic shift_q, shift_d;
    logic rdy_q, rdy_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic cnt_clr, cnt_inc, cnt_term;
    logic [CNT_W-1:0] cnt;
    logic skip_q;

`ifdef MUL_CTRL_ZERO_SKIP_EN
    logic skip_d;

    // Zero-multiplier flag is captured only when a multiply is accepted.
    always_comb begin
        skip_d = skip_q;
        if (state_q == IDLE && start)
            skip_d = mplier_zero;
    end

    always_ff @(posedge clk) begin
        if (rst)
            skip_q <= 1'b0;
        else
            skip_q <= skip_d;
    end
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign skip_q             = 1'b0;
`endif

    mul_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (cnt),
        .term_c (cnt_term)
    );

    // Next state and registered Moore outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = skip_q ? DONE : ITER;
            end
            ITER: begin
                cnt_inc = 1'b1;
                if (cnt_term) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d   = (state_d == IDLE);
        load_d  = (state_d == LOAD);
        shift_d = (state_d == ITER);
        busy_d  = (state_d == LOAD) || (state_d == ITER);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            load_q  <= load_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load_ctrl      = load_q;
    assign shift_ctrl     = shift_q;
    assign adding_ctrl    = shift_q & lsb;
    assign rdy            = rdy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign w_ctrl_Product = cnt;

endmodule

// File: tb/tb_mul_control.sv
// Cycle-accurate scoreboard bench for mul_control; honours MUL_CTRL_ZERO_SKIP_EN.
module tb_mul_control;
    import mul_pkg::*;

    localparam int unsigned W  = MUL_WIDTH;
    localparam int unsigned CW = MUL_CNT_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          lsb = 1'b0;
    logic          mplier_zero = 1'b0;
    logic          load_ctrl, adding_ctrl, shift_ctrl, rdy, busy, done;
    logic [CW-1:0] w_ctrl_Product;

    mul_control #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .lsb            (lsb),
        .mplier_zero    (mplier_zero),
        .load_ctrl      (load_ctrl),
        .adding_ctrl    (adding_ctrl),
        .shift_ctrl     (shift_ctrl),
        .w_ctrl_Product (w_ctrl_Product),
        .rdy            (rdy),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          load;
        logic          add;
        logic          shift;
        logic          rdy;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] last_cnt = '0;

    function automatic obs_t sample();
        obs_t o;
        o.load  = load_ctrl;
        o.add   = adding_ctrl;
        o.shift = shift_ctrl;
        o.rdy   = rdy;
        o.busy  = busy;
        o.done  = done;
        o.cnt   = w_ctrl_Product;
        return o;
    endfunction

    // Expected outputs c cycles after the cycle in which start was driven.
    function automatic obs_t exp_at(int c, int iters, logic l, logic [CW-1:0] prev);
        obs_t e;
        logic [CW-1:0] fin;
        e     = '0;
        fin   = (iters == 0) ? '0 : CW'(iters - 1);
        e.cnt = prev;
        if (c == 1) begin
            e.load = 1'b1; e.busy = 1'b1;
        end else if (c >= 2 && c <= iters + 1) begin
            e.shift = 1'b1; e.busy = 1'b1; e.add = l; e.cnt = CW'(c - 2);
        end else if (c == iters + 2) begin
            e.done = 1'b1; e.cnt = fin;
        end else begin
            e.rdy = 1'b1;
            if (c > iters + 2) e.cnt = fin;
        end
        return e;
    endfunction

    task automatic test_reset();
        obs_t got, want;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rst   = (c == 0);
            start = (c == 0);
            lsb   = 1'b1;
            sb.push_back(exp_at(-1, W, 1'b0, '0));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset c=%0d got=%b want=%b", c, got, want);
            end
        end
        last_cnt = '0;
    endtask

    task automatic test_basic();
        obs_t got, want;
        logic [31:0] mplier = 32'd50;
        int ndone = 0;
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk);
            start = (c == 0);
            lsb   = (c >= 2 && c <= W + 1) ? mplier[c-2] : 1'b1;
            sb.push_back(exp_at(c, W, lsb, last_cnt));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got.done) ndone++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL basic c=%0d got=%b want=%b", c, got, want);
            end
        end
        vectors++;
        if (ndone !== 1) begin
            miscompares++;
            $display("FAIL basic_done_count got=%0d want=1", ndone);
        end
        last_cnt = CW'(W - 1);
    endtask

    task automatic test_ignored_start();
        obs_t got, want;
        for (int c = 0; c <= 37; c++) begin
            @(negedge clk);
            start = (c == 0) || (c >= 12 && c <= 14) || (c == W + 2);
            lsb   = 1'($urandom);
            sb.push_back(exp_at(c, W, lsb, last_cnt));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL ignored_start c=%0d got=%b want=%b", c, got, want);
            end
        end
        last_cnt = CW'(W - 1);
    endtask

    task automatic test_reset_mid();
        obs_t got, want, idle0;
        int ndone = 0;
        idle0 = '0; idle0.rdy = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            start = (c == 0);
            rst   = (c == 17);
            lsb   = 1'($urandom);
            sb.push_back((c == 18) ? idle0 : exp_at(c, W, lsb, last_cnt));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got.done) ndone++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid c=%0d got=%b want=%b", c, got, want);
            end
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_done got=%0d want=0", ndone);
        end
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            start = (c == 0);
            lsb   = 1'($urandom);
            sb.push_back(exp_at(c, W, lsb, '0));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_rerun c=%0d got=%b want=%b", c, got, want);
            end
        end
        last_cnt = CW'(W - 1);
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        int period = W + 3;
        int done_at[$];
        int nload = 0;
        for (int c = 0; c <= 2 * period + 2; c++) begin
            @(negedge clk);
            start = (c < 2 * period);
            lsb   = 1'($urandom);
            sb.push_back(exp_at((c < period) ? c : c - period, W, lsb,
                                (c < period) ? last_cnt : CW'(W - 1)));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got.done) done_at.push_back(c);
            if (got.load) nload++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL b2b c=%0d got=%b want=%b", c, got, want);
            end
        end
        vectors++;
        if (done_at.size() != 2 || (done_at[1] - done_at[0]) != period || nload != 2) begin
            miscompares++;
            $display("FAIL b2b_spacing got dones=%0d loads=%0d want dones=2 spacing=%0d loads=2",
                     done_at.size(), nload, period);
        end
        last_cnt = CW'(W - 1);
    endtask

    task automatic test_zero_skip();
        obs_t got, want;
        int done_at = -1;
`ifdef MUL_CTRL_ZERO_SKIP_EN
        int iters = 0;
`else
        int iters = W;
`endif
        for (int c = 0; c <= iters + 4; c++) begin
            @(negedge clk);
            start       = (c == 0);
            mplier_zero = (c == 0);
            lsb         = 1'($urandom);
            sb.push_back(exp_at(c, iters, lsb, last_cnt));
            #1;
            got = sample(); want = sb.pop_front(); vectors++;
            if (got.done) done_at = c;
            if (got !== want) begin
                miscompares++;
                $display("FAIL zero_skip c=%0d got=%b want=%b", c, got, want);
            end
        end
        vectors++;
        if (done_at != iters + 2) begin
            miscompares++;
            $display("FAIL zero_skip_done_cycle got=%0d want=%0d", done_at, iters + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_zero_skip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
